// File: rtl/imem_sync.sv
// Synchronous instruction memory with valid/ready fetch handshake, programmable
// wait states and a run-time load port. Define IMEM_FAULT_CHK_EN to enable fetch-address fault reporting.
module imem_sync #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_reqValid,
  output logic                     o_reqReady,
  input  logic [31:0]              i_address,
  output logic                     o_respValid,
  input  logic                     i_respReady,
  output logic [DATA_W-1:0]        o_data,
  output logic                     o_fault,
  input  logic                     i_loadWe,
  input  logic [$clog2(DEPTH)-1:0] i_loadAddr,
  input  logic [DATA_W-1:0]        i_loadData
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [3:0]        r_count;
  logic [3:0]        w_nextCount;
  logic [31:0]       r_addr;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_reqReady;
  logic              w_respValid;
  logic              w_accept;
  logic              w_capture;
  logic [31:0]       w_capAddr;
  logic [IDX_W-1:0]  w_capIdx;
  logic              w_capFault;

  // Next-state logic; a request accepted from RESP re-enters WAIT/RESP directly.
  always_comb begin
    w_nextState = r_state;
    w_nextCount = r_count;
    w_reqReady  = 1'b0;
    w_respValid = 1'b0;
    w_capture   = 1'b0;
    w_accept    = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_reqReady = 1'b1;
      end
      S_WAIT: begin
        if (r_count == 4'd0) begin
          w_nextState = S_RESP;
          w_capture   = 1'b1;
        end else begin
          w_nextCount = r_count - 4'd1;
        end
      end
      S_RESP: begin
        w_respValid = 1'b1;
        w_reqReady  = i_respReady;
        if (i_respReady && !i_reqValid) begin
          w_nextState = S_IDLE;
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase

    w_accept = w_reqReady && i_reqValid;
    if (w_accept) begin
      if (WAIT_STATES > 0) begin
        w_nextState = S_WAIT;
        w_nextCount = CNT_INIT;
      end else begin
        w_nextState = S_RESP;
        w_capture   = 1'b1;
      end
    end
  end

  // With zero wait states the capture edge is the accept edge, so the live address is used.
  assign w_capAddr = w_accept ? i_address : r_addr;
  assign w_capIdx  = w_capAddr[IDX_W+1:2];

`ifdef IMEM_FAULT_CHK_EN
  logic r_fault;

  assign w_capFault = (w_capAddr[1:0] != 2'b00) || (|w_capAddr[31:IDX_W+2]);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_fault <= 1'b0;
    end else if (w_capture) begin
      r_fault <= w_capFault;
    end
  end

  assign o_fault = r_fault;
`else
  logic w_unusedAddrBits;

  assign w_capFault       = 1'b0;
  assign w_unusedAddrBits = ^{w_capAddr[1:0], w_capAddr[31:IDX_W+2]};
  assign o_fault          = 1'b0;
`endif

  // State, wait counter, latched address and response word; the read sees pre-write contents.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_count <= 4'd0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_nextState;
      r_count <= w_nextCount;
      if (w_accept) begin
        r_addr <= i_address;
      end
      if (w_capture) begin
        r_data <= w_capFault ? '0 : r_mem[w_capIdx];
      end
    end
  end

  // Program store is deliberately outside reset so loaded code survives a core reset.
  always_ff @(posedge i_clk) begin
    if (i_loadWe) begin
      r_mem[i_loadAddr] <= i_loadData;
    end
  end

  assign o_reqReady  = w_reqReady;
  assign o_respValid = w_respValid;
  assign o_data      = r_data;

endmodule

// File: tb/tb_imem_sync.sv
// Randomised bench for imem_sync: three instances (0, 3 and 5 wait states) share the
// load port and are checked against an array-based memory model.
module tb_imem_sync;

  localparam int DEPTH = 16;
  localparam int NUM   = 3;
  localparam int WS_TAB [NUM] = '{0, 3, 5};

  logic        clk = 1'b0;
  logic        reset;
  logic        loadWe;
  logic [3:0]  loadAddr;
  logic [31:0] loadData;

  logic        reqValid  [NUM];
  logic [31:0] address   [NUM];
  logic        respReady [NUM];
  logic        reqReady  [NUM];
  logic        respValid [NUM];
  logic [31:0] data      [NUM];
  logic        fault     [NUM];

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NUM; g++) begin : g_dut
    imem_sync #(
      .DATA_W(32),
      .DEPTH(DEPTH),
      .WAIT_STATES(WS_TAB[g])
    ) u_dut (
      .i_clk(clk),
      .i_reset(reset),
      .i_reqValid(reqValid[g]),
      .o_reqReady(reqReady[g]),
      .i_address(address[g]),
      .o_respValid(respValid[g]),
      .i_respReady(respReady[g]),
      .o_data(data[g]),
      .o_fault(fault[g]),
      .i_loadWe(loadWe),
      .i_loadAddr(loadAddr),
      .i_loadData(loadData)
    );
  end

  // Reference memory; prevMem holds the contents as they were just before the latest edge.
  logic [31:0] refMem  [DEPTH];
  logic [31:0] prevMem [DEPTH];

  always @(posedge clk) begin
    prevMem = refMem;
    if (loadWe) refMem[loadAddr] = loadData;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic expFault(input logic [31:0] a);
`ifdef IMEM_FAULT_CHK_EN
    return (a % 4 != 0) || (a >= 4 * DEPTH);
`else
    return (a != a);
`endif
  endfunction

  function automatic logic [3:0] idxOf(input logic [31:0] a);
    return 4'((a / 4) % DEPTH);
  endfunction

  function automatic logic [31:0] expData(input logic [31:0] a);
    if (expFault(a)) return 32'h0;
    return prevMem[idxOf(a)];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doLoad(input int idx, input logic [31:0] d);
    loadWe   = 1'b1;
    loadAddr = 4'(idx);
    loadData = d;
    tick();
    loadWe = 1'b0;
  endtask

  // Single fetch: the request is accepted on the first edge and the response must appear
  // after WAIT_STATES further edges; optionally stalls and loads on the capture edge.
  task automatic applyStimulus(input int u, input logic [31:0] a, input int stall,
                               input logic [31:0] stallData, input bit rbw, input logic [31:0] rbwData);
    int n;
    int w;
    logic [31:0] held;
    w = WS_TAB[u];
    checkOutput("ready_idle", 32'(reqReady[u]), 32'd1);
    reqValid[u]  = 1'b1;
    address[u]   = a;
    respReady[u] = 1'b0;
    if (rbw && w == 0) begin
      loadWe = 1'b1; loadAddr = idxOf(a); loadData = rbwData;
    end
    n = 0;
    do begin
      tick();
      n++;
      loadWe      = 1'b0;
      address[u]  = $urandom;
      reqValid[u] = 1'($urandom);
      if (rbw && n == w) begin
        loadWe = 1'b1; loadAddr = idxOf(a); loadData = rbwData;
      end
      if (!respValid[u]) checkOutput("ready_wait", 32'(reqReady[u]), 32'd0);
    end while (!respValid[u] && n < 40);
    loadWe = 1'b0;
    checkOutput("latency", 32'(n), 32'(w + 1));
    held = expData(a);
    checkOutput("data", data[u], held);
    checkOutput("fault", 32'(fault[u]), 32'(expFault(a)));
    for (int s = 0; s < stall; s++) begin
      loadWe = 1'b1; loadAddr = idxOf(a); loadData = stallData;
      reqValid[u] = 1'($urandom);
      tick();
      loadWe = 1'b0;
      checkOutput("stall_valid", 32'(respValid[u]), 32'd1);
      checkOutput("stall_data", data[u], held);
      checkOutput("stall_ready", 32'(reqReady[u]), 32'd0);
    end
    reqValid[u]  = 1'b0;
    respReady[u] = 1'b1;
    tick();
    respReady[u] = 1'b0;
    checkOutput("release_valid", 32'(respValid[u]), 32'd0);
    checkOutput("release_ready", 32'(reqReady[u]), 32'd1);
  endtask

  // Two fetches with RespReady held high; the second is accepted in the response cycle.
  task automatic fetchPair(input int u, input logic [31:0] a0, input logic [31:0] a1);
    int n;
    int w;
    w = WS_TAB[u];
    reqValid[u] = 1'b1; address[u] = a0; respReady[u] = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!respValid[u] && n < 40);
    checkOutput("pair_lat0", 32'(n), 32'(w + 1));
    checkOutput("pair_data0", data[u], expData(a0));
    checkOutput("pair_fault0", 32'(fault[u]), 32'(expFault(a0)));
    address[u] = a1;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) reqValid[u] = 1'b0;
    end while (!respValid[u] && n < 40);
    checkOutput("pair_lat1", 32'(n), 32'(w + 1));
    checkOutput("pair_data1", data[u], expData(a1));
    checkOutput("pair_fault1", 32'(fault[u]), 32'(expFault(a1)));
    tick();
    respReady[u] = 1'b0;
    checkOutput("pair_end_valid", 32'(respValid[u]), 32'd0);
    checkOutput("pair_end_ready", 32'(reqReady[u]), 32'd1);
  endtask

  // Reset two cycles into a long fetch, with a load write landing on the reset edge.
  task automatic resetMid(input int u, input logic [31:0] a, input int wIdx, input logic [31:0] wData);
    reqValid[u] = 1'b1; address[u] = a; respReady[u] = 1'b1;
    tick();
    reqValid[u] = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    loadWe = 1'b1; loadAddr = 4'(wIdx); loadData = wData;
    tick();
    reset = 1'b0;
    loadWe = 1'b0;
    checkOutput("rst_valid", 32'(respValid[u]), 32'd0);
    checkOutput("rst_data", data[u], 32'h0);
    checkOutput("rst_fault", 32'(fault[u]), 32'd0);
    checkOutput("rst_ready", 32'(reqReady[u]), 32'd1);
    for (int i = 0; i < WS_TAB[u] + 3; i++) begin
      tick();
      checkOutput("rst_no_resp", 32'(respValid[u]), 32'd0);
    end
    respReady[u] = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    int u;

    reset = 1'b1; loadWe = 1'b0; loadAddr = '0; loadData = '0;
    for (int i = 0; i < NUM; i++) begin
      reqValid[i] = 1'b0; address[i] = '0; respReady[i] = 1'b0;
    end
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      checkOutput("reset_valid", 32'(respValid[i]), 32'd0);
      checkOutput("reset_data", data[i], 32'h0);
      checkOutput("reset_fault", 32'(fault[i]), 32'd0);
      checkOutput("reset_ready", 32'(reqReady[i]), 32'd1);
    end

    for (int i = 0; i < DEPTH; i++) doLoad(i, $urandom);
    doLoad(0, 32'h34080032);
    doLoad(1, 32'hac080000);
    doLoad(2, 32'h3408001e);

    fetchPair(0, 32'h0, 32'h4);
    applyStimulus(1, 32'h4, 5, 32'h0, 1'b0, 32'h0);
    applyStimulus(0, 32'h8, 0, 32'h0, 1'b1, 32'h11450005);
    applyStimulus(0, 32'h8, 0, 32'h0, 1'b0, 32'h0);
    applyStimulus(1, 32'hC, 1, $urandom, 1'b1, $urandom);
    applyStimulus(0, 32'h6, 0, 32'h0, 1'b0, 32'h0);
    applyStimulus(0, 32'(4 * DEPTH), 0, 32'h0, 1'b0, 32'h0);
    applyStimulus(2, 32'h6, 0, 32'h0, 1'b0, 32'h0);
    applyStimulus(2, 32'(4 * DEPTH), 2, $urandom, 1'b0, 32'h0);

    resetMid(2, 32'h4, 5, 32'hcafe0005);
    applyStimulus(2, 32'h14, 0, 32'h0, 1'b0, 32'h0);
    applyStimulus(2, 32'h0, 0, 32'h0, 1'b0, 32'h0);
    applyStimulus(1, 32'h8, 0, 32'h0, 1'b0, 32'h0);

    for (int it = 0; it < 80; it++) begin
      u = $urandom_range(0, NUM - 1);
      if ($urandom_range(0, 3) == 0) doLoad($urandom_range(0, DEPTH - 1), $urandom);
      for (int k = 0; k < 2; k++) begin
        case ($urandom_range(0, 3))
          0, 1:    b = 32'(4 * $urandom_range(0, DEPTH - 1));
          2:       b = 32'($urandom_range(0, 4 * DEPTH - 1));
          default: b = $urandom;
        endcase
        if (k == 0) a = b;
      end
      if ($urandom_range(0, 3) == 0) fetchPair(u, a, b);
      else applyStimulus(u, a, $urandom_range(0, 3), $urandom, 1'($urandom), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
